// File: rtl/lpc_pkg.sv
// ---------------------------------------------------------------------------
// lpc_pkg
//  Shared LPC definitions used by the LPC host (initiator) and the LPC
//  decoder/sniffer: START/ABORT/turnaround nibbles, SYNC codes, cycle-type
//  encoding, response status codes and the host state enumeration.
//  Helpers build the CYCTYPE+DIR nibble and select address nibbles
//  most-significant first.
// ---------------------------------------------------------------------------
package lpc_pkg;

    // Frame-level nibbles
    localparam logic [3:0] LPC_START_NIB   = 4'b0000;
    localparam logic [3:0] LPC_ABORT_NIB   = 4'b1111;
    localparam logic [3:0] LPC_TAR_NIB     = 4'b1111;
    localparam logic [3:0] LPC_IDLE_NIB    = 4'b1111;

    // SYNC codes driven by the peripheral
    localparam logic [3:0] SYNC_READY      = 4'b0000;
    localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
    localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;
    localparam logic [3:0] SYNC_ERROR      = 4'b1010;

    // Cycle type / direction field values
    localparam logic CYC_SPACE_IO  = 1'b0;
    localparam logic CYC_SPACE_MEM = 1'b1;
    localparam logic CYC_DIR_READ  = 1'b0;
    localparam logic CYC_DIR_WRITE = 1'b1;

    // Response status codes
    localparam logic [1:0] RSP_OK    = 2'b00;
    localparam logic [1:0] RSP_ERR   = 2'b01;
    localparam logic [1:0] RSP_ABORT = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_CYCTYPE,
        ST_ADDR,
        ST_WDATA,
        ST_HTAR1,
        ST_HTAR2,
        ST_SYNC,
        ST_RDATA,
        ST_PTAR1,
        ST_PTAR2,
        ST_DONE,
        ST_ABORT
    } host_state_e;

    // CYCTYPE+DIR nibble: bit2 selects memory space, bit1 selects write.
    function automatic logic [3:0] cyctype_nibble(input logic mem, input logic write);
        return {1'b0, mem, write, 1'b0};
    endfunction

    // Address nibble for transfer position idx (0 = first on the wire).
    // I/O cycles carry addr[15:0] only, memory cycles the full 32 bits.
    function automatic logic [3:0] addr_nibble(input logic [31:0] addr,
                                               input logic        mem,
                                               input logic [2:0]  idx);
        logic [2:0] pos;
        pos = mem ? (3'd7 - idx) : (3'd3 - idx);
        return addr[{pos, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/lpc_sync_mon.sv
// ---------------------------------------------------------------------------
// lpc_sync_mon
//  Classifies the LAD value sampled while the host sits in SYNC and keeps
//  the consecutive no-sync (idle) and wait counters.
//  Ports:
//   lpc_clock, lpc_reset  clock, synchronous active-low reset
//   in_sync               host is in the SYNC state this clock
//   lpc_ad_in[3:0]        sampled LAD
//   sync_ok               0000 seen (ready)
//   sync_err              1010 seen (error, data still follows on reads)
//   sync_abort            this sample reaches SYNC_TIMEOUT no-syncs or
//                         WAIT_LIMIT waits in a row
// ---------------------------------------------------------------------------
module lpc_sync_mon
    import lpc_pkg::*;
#(
    parameter int SYNC_TIMEOUT = 8,
    parameter int WAIT_LIMIT   = 256
) (
    input  logic       lpc_clock,
    input  logic       lpc_reset,
    input  logic       in_sync,
    input  logic [3:0] lpc_ad_in,
    output logic       sync_ok,
    output logic       sync_err,
    output logic       sync_abort
);

    localparam int IDLE_W = $clog2(SYNC_TIMEOUT) + 1;
    localparam int WAIT_W = $clog2(WAIT_LIMIT) + 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(SYNC_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);

    logic [IDLE_W-1:0] idle_cnt, idle_inc;
    logic [WAIT_W-1:0] wait_cnt, wait_inc;
    logic              is_wait, is_none;

    function automatic int sat_inc(input int value, input int limit);
        return (value >= limit) ? limit : value + 1;
    endfunction

    always_comb begin
        sync_ok  = in_sync && (lpc_ad_in == SYNC_READY);
        sync_err = in_sync && (lpc_ad_in == SYNC_ERROR);
        is_wait  = in_sync && ((lpc_ad_in == SYNC_SHORT_WAIT) ||
                               (lpc_ad_in == SYNC_LONG_WAIT));
        is_none  = in_sync && !sync_ok && !sync_err && !is_wait;
        idle_inc = IDLE_W'(sat_inc(int'(idle_cnt), SYNC_TIMEOUT));
        wait_inc = WAIT_W'(sat_inc(int'(wait_cnt), WAIT_LIMIT));
        // Abort on the sample that brings a count to its limit, so exactly
        // SYNC_TIMEOUT (or WAIT_LIMIT) SYNC clocks are spent before ABORT.
        sync_abort = (is_none && (idle_inc == IDLE_MAX)) ||
                     (is_wait && (wait_inc == WAIT_MAX));
    end

    always_ff @(posedge lpc_clock) begin
        if (!lpc_reset || !in_sync) begin
            idle_cnt <= '0;
            wait_cnt <= '0;
        end else if (is_wait) begin
            wait_cnt <= wait_inc;
            idle_cnt <= '0;
        end else if (is_none) begin
            idle_cnt <= idle_inc;
            wait_cnt <= '0;
        end else begin
            idle_cnt <= '0;
            wait_cnt <= '0;
        end
    end

endmodule

// File: rtl/lpc_host.sv
// ---------------------------------------------------------------------------
// lpc_host
//  LPC bus initiator. Accepts one single-byte I/O or memory request at a
//  time (valid/ready), runs the LPC cycle on LAD/LFRAME# and reports the
//  result with a one-clock rsp_valid pulse.
//  Ports:
//   lpc_clock, lpc_reset        clock, synchronous active-low reset
//   lpc_ad_out/oe, lpc_ad_in    LAD drive value, drive enable, sampled LAD
//   lpc_frame                   LFRAME#, active low
//   req_valid/ready/write/mem/addr/data   request side
//   rsp_valid/data/status       completion pulse, read data, status
//  All bus and response outputs are registered: the next-state logic also
//  computes what the bus must show in that next state.
// ---------------------------------------------------------------------------
module lpc_host
    import lpc_pkg::*;
#(
    parameter int SYNC_TIMEOUT = 8,
    parameter int WAIT_LIMIT   = 256
) (
    input  logic        lpc_clock,
    input  logic        lpc_reset,
    output logic [3:0]  lpc_ad_out,
    output logic        lpc_ad_oe,
    input  logic [3:0]  lpc_ad_in,
    output logic        lpc_frame,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_mem,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic [1:0]  rsp_status
);

    host_state_e state, state_n;
    logic [2:0]  nib, nib_n;
    logic        ready_q;
    logic        accept;
    logic        err_q;

    logic        cap_write, cap_mem;
    logic [31:0] cap_addr;
    logic [7:0]  cap_wdata;
    logic [7:0]  rdata;

    logic        frame_n, oe_n;
    logic [3:0]  ad_n;

    logic        sync_ok, sync_err, sync_abort;

    assign req_ready = ready_q;
    assign accept    = req_valid && ready_q;

    lpc_sync_mon #(
        .SYNC_TIMEOUT (SYNC_TIMEOUT),
        .WAIT_LIMIT   (WAIT_LIMIT)
    ) u_sync_mon (
        .lpc_clock  (lpc_clock),
        .lpc_reset  (lpc_reset),
        .in_sync    (state == ST_SYNC),
        .lpc_ad_in  (lpc_ad_in),
        .sync_ok    (sync_ok),
        .sync_err   (sync_err),
        .sync_abort (sync_abort)
    );

    // Next state and the bus values belonging to that next state
    always_comb begin
        state_n = state;
        nib_n   = nib;
        case (state)
            ST_IDLE:    if (accept) state_n = ST_START;
            ST_START:   begin state_n = ST_CYCTYPE; nib_n = '0; end
            ST_CYCTYPE: begin state_n = ST_ADDR;    nib_n = '0; end
            ST_ADDR: begin
                if (nib == (cap_mem ? 3'd7 : 3'd3)) begin
                    state_n = cap_write ? ST_WDATA : ST_HTAR1;
                    nib_n   = '0;
                end else begin
                    nib_n = nib + 3'd1;
                end
            end
            ST_WDATA: begin
                if (nib == 3'd1) begin
                    state_n = ST_HTAR1;
                    nib_n   = '0;
                end else begin
                    nib_n = nib + 3'd1;
                end
            end
            ST_HTAR1:   state_n = ST_HTAR2;
            ST_HTAR2:   state_n = ST_SYNC;
            ST_SYNC: begin
                if (sync_abort) begin
                    state_n = ST_ABORT;
                    nib_n   = '0;
                end else if (sync_ok || sync_err) begin
                    state_n = cap_write ? ST_PTAR1 : ST_RDATA;
                    nib_n   = '0;
                end
            end
            ST_RDATA: begin
                if (nib == 3'd1) begin
                    state_n = ST_PTAR1;
                    nib_n   = '0;
                end else begin
                    nib_n = nib + 3'd1;
                end
            end
            ST_PTAR1:   state_n = ST_PTAR2;
            ST_PTAR2:   state_n = ST_DONE;
            ST_ABORT: begin
                if (nib == 3'd3) begin
                    state_n = ST_DONE;
                    nib_n   = '0;
                end else begin
                    nib_n = nib + 3'd1;
                end
            end
            ST_DONE:    state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase

        frame_n = 1'b1;
        oe_n    = 1'b0;
        ad_n    = LPC_IDLE_NIB;
        case (state_n)
            ST_START: begin
                frame_n = 1'b0;
                oe_n    = 1'b1;
                ad_n    = LPC_START_NIB;
            end
            ST_CYCTYPE: begin
                oe_n = 1'b1;
                ad_n = cyctype_nibble(cap_mem, cap_write);
            end
            ST_ADDR: begin
                oe_n = 1'b1;
                ad_n = addr_nibble(cap_addr, cap_mem, nib_n);
            end
            ST_WDATA: begin
                oe_n = 1'b1;
                ad_n = nib_n[0] ? cap_wdata[7:4] : cap_wdata[3:0];
            end
            ST_HTAR1: begin
                oe_n = 1'b1;
                ad_n = LPC_TAR_NIB;
            end
            ST_ABORT: begin
                frame_n = 1'b0;
                oe_n    = 1'b1;
                ad_n    = LPC_ABORT_NIB;
            end
            default: ;
        endcase
    end

    always_ff @(posedge lpc_clock) begin
        if (!lpc_reset) begin
            state      <= ST_IDLE;
            nib        <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            lpc_frame  <= 1'b1;
            lpc_ad_oe  <= 1'b0;
            lpc_ad_out <= LPC_IDLE_NIB;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_status <= RSP_OK;
        end else begin
            state      <= state_n;
            nib        <= nib_n;
            ready_q    <= (state_n == ST_IDLE);
            lpc_frame  <= frame_n;
            lpc_ad_oe  <= oe_n;
            lpc_ad_out <= ad_n;
            rsp_valid  <= (state_n == ST_DONE);
            if (accept) begin
                err_q <= 1'b0;
            end else if (sync_err) begin
                err_q <= 1'b1;
            end
            if (state_n == ST_DONE) begin
                if (state == ST_ABORT) begin
                    rsp_data   <= '0;
                    rsp_status <= RSP_ABORT;
                end else begin
                    rsp_data   <= cap_write ? 8'h00 : rdata;
                    rsp_status <= err_q ? RSP_ERR : RSP_OK;
                end
            end
        end
    end

    // Request capture and read-data assembly carry no reset
    always_ff @(posedge lpc_clock) begin
        if (accept) begin
            cap_write <= req_write;
            cap_mem   <= req_mem;
            cap_addr  <= req_addr;
            cap_wdata <= req_data;
        end
        if (state == ST_RDATA) begin
            if (nib[0]) begin
                rdata[7:4] <= lpc_ad_in;
            end else begin
                rdata[3:0] <= lpc_ad_in;
            end
        end
    end

endmodule

// File: tb/tb_lpc_host.sv
// ---------------------------------------------------------------------------
// tb_lpc_host
//  Directed bench for lpc_host. A transaction-level model turns each request
//  and the peripheral's SYNC/data answers into the expected per-clock bus
//  picture and response; a compare process checks the DUT every clock.
// ---------------------------------------------------------------------------
module tb_lpc_host;

    logic        lpc_clock = 1'b0;
    logic        lpc_reset = 1'b0;
    logic [3:0]  lpc_ad_out;
    logic        lpc_ad_oe;
    logic [3:0]  lpc_ad_in = 4'hF;
    logic        lpc_frame;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_mem   = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [7:0]  req_data  = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_status;

    lpc_host #(.SYNC_TIMEOUT(8), .WAIT_LIMIT(256)) dut (
        .lpc_clock  (lpc_clock),
        .lpc_reset  (lpc_reset),
        .lpc_ad_out (lpc_ad_out),
        .lpc_ad_oe  (lpc_ad_oe),
        .lpc_ad_in  (lpc_ad_in),
        .lpc_frame  (lpc_frame),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_mem    (req_mem),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_status (rsp_status)
    );

    always #5 lpc_clock = ~lpc_clock;

    typedef struct {
        logic       frame;
        logic       oe;
        logic [3:0] ad;
        logic       ready;
        logic       rv;
        logic [7:0] data;
        logic [1:0] status;
    } exp_t;

    exp_t        exp_q[$];
    logic [3:0]  in_q[$];
    logic [3:0]  sync_src[$];
    logic [3:0]  model_ad[$];
    exp_t        cur;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc_idx = 0;
    int          rsp_idx = 0;
    logic [7:0]  last_data;
    logic [1:0]  last_status;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-clock comparison against the model's expected bus picture
    always @(negedge lpc_clock) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            cyc_idx++;
            chk("frame", 32'(lpc_frame), 32'(cur.frame));
            chk("ad_oe", 32'(lpc_ad_oe), 32'(cur.oe));
            if (cur.oe) chk("ad_out", 32'(lpc_ad_out), 32'(cur.ad));
            chk("req_ready", 32'(req_ready), 32'(cur.ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(cur.rv));
            if (cur.rv) begin
                chk("rsp_data", 32'(rsp_data), 32'(cur.data));
                chk("rsp_status", 32'(rsp_status), 32'(cur.status));
                rsp_idx     = cyc_idx;
                last_data   = rsp_data;
                last_status = rsp_status;
            end
        end
    end

    task automatic mpush(input logic frame, input logic oe, input logic [3:0] ad,
                         input logic [3:0] pin, input logic rv, input logic [7:0] data,
                         input logic [1:0] status, input logic ready);
        exp_t e;
        e.frame = frame; e.oe = oe; e.ad = ad; e.ready = ready;
        e.rv = rv; e.data = data; e.status = status;
        exp_q.push_back(e);
        in_q.push_back(pin);
        if (oe) model_ad.push_back(ad);
    endtask

    // Build the expected cycle from the request and the peripheral answers
    task automatic build_model(input logic wr, input logic mem, input logic [31:0] addr,
                               input logic [7:0] wdata, input logic [7:0] rd,
                               output logic [7:0] m_data, output logic [1:0] m_status,
                               output int m_done, output int m_sync);
        int idle_run = 0;
        int wait_run = 0;
        int outcome = 0;  // 0 pending, 1 ok, 2 error sync, 3 abort
        int nn;
        exp_q.delete(); in_q.delete(); model_ad.delete();
        m_sync = 0;
        mpush(1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 8'h00, 2'b00, 1'b0);
        mpush(1'b1, 1'b1, {1'b0, mem, wr, 1'b0}, 4'hF, 1'b0, 8'h00, 2'b00, 1'b0);
        nn = mem ? 8 : 4;
        for (int i = nn - 1; i >= 0; i--)
            mpush(1'b1, 1'b1, 4'((addr >> (4 * i)) & 32'hF), 4'hF, 1'b0, 8'h00, 2'b00, 1'b0);
        if (wr) begin
            mpush(1'b1, 1'b1, wdata[3:0], 4'hF, 1'b0, 8'h00, 2'b00, 1'b0);
            mpush(1'b1, 1'b1, wdata[7:4], 4'hF, 1'b0, 8'h00, 2'b00, 1'b0);
        end
        mpush(1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 8'h00, 2'b00, 1'b0);
        mpush(1'b1, 1'b0, 4'hF, 4'hF, 1'b0, 8'h00, 2'b00, 1'b0);
        for (int k = 0; k < sync_src.size() && outcome == 0; k++) begin
            logic [3:0] s;
            s = sync_src[k];
            mpush(1'b1, 1'b0, 4'hF, s, 1'b0, 8'h00, 2'b00, 1'b0);
            m_sync++;
            if (s == 4'h0) outcome = 1;
            else if (s == 4'hA) outcome = 2;
            else if (s == 4'h5 || s == 4'h6) begin
                wait_run++; idle_run = 0;
                if (wait_run == 256) outcome = 3;
            end else begin
                idle_run++; wait_run = 0;
                if (idle_run == 8) outcome = 3;
            end
        end
        if (outcome == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL model: sync stimulus ran out without a terminal code");
        end
        if (outcome == 3) begin
            for (int i = 0; i < 4; i++)
                mpush(1'b0, 1'b1, 4'hF, 4'hF, 1'b0, 8'h00, 2'b00, 1'b0);
            m_data = 8'h00; m_status = 2'b10;
        end else begin
            if (!wr) begin
                mpush(1'b1, 1'b0, 4'hF, rd[3:0], 1'b0, 8'h00, 2'b00, 1'b0);
                mpush(1'b1, 1'b0, 4'hF, rd[7:4], 1'b0, 8'h00, 2'b00, 1'b0);
            end
            mpush(1'b1, 1'b0, 4'hF, 4'hF, 1'b0, 8'h00, 2'b00, 1'b0);
            mpush(1'b1, 1'b0, 4'hF, 4'hF, 1'b0, 8'h00, 2'b00, 1'b0);
            m_data   = wr ? 8'h00 : rd;
            m_status = (outcome == 2) ? 2'b01 : 2'b00;
        end
        mpush(1'b1, 1'b0, 4'hF, 4'hF, 1'b1, m_data, m_status, 1'b0);
        m_done = exp_q.size();
        mpush(1'b1, 1'b0, 4'hF, 4'hF, 1'b0, 8'h00, 2'b00, 1'b1);
    endtask

    // Issue one request and play the peripheral; entered at posedge+2
    task automatic run_txn(input logic wr, input logic mem, input logic [31:0] addr,
                           input logic [7:0] wdata, input logic [7:0] rd,
                           output logic [7:0] m_data, output logic [1:0] m_status,
                           output int m_done, output int m_sync);
        int guard = 0;
        req_write = wr; req_mem = mem; req_addr = addr; req_data = wdata;
        req_valid = 1'b1;
        while (!req_ready && guard < 20) begin
            @(posedge lpc_clock); #2;
            guard++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            m_data = 8'h00; m_status = 2'b00; m_done = 0; m_sync = 0;
            return;
        end
        @(posedge lpc_clock); #2;
        req_valid = 1'b0;
        req_addr  = 32'hDEAD_BEEF;
        req_data  = 8'h00;
        cyc_idx   = 0;
        build_model(wr, mem, addr, wdata, rd, m_data, m_status, m_done, m_sync);
        for (int k = 0; k < in_q.size(); k++) begin
            lpc_ad_in = in_q[k];
            @(posedge lpc_clock); #2;
        end
        lpc_ad_in = 4'hF;
        guard = 0;
        while (exp_q.size() > 0 && guard < 5) begin
            @(posedge lpc_clock); #2;
            guard++;
        end
        if (exp_q.size() > 0) chk("compare_drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    logic [7:0] md;
    logic [1:0] ms;
    int         mdone, msync;
    logic [3:0] lit1 [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        lit1 = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h8, 4'h0, 4'h5, 4'hA, 4'hF};
        lpc_reset = 1'b0;
        repeat (3) @(posedge lpc_clock);
        #2;
        chk("rst_frame", 32'(lpc_frame), 32'd1);
        chk("rst_oe", 32'(lpc_ad_oe), 32'd0);
        chk("rst_ad", 32'(lpc_ad_out), 32'hF);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_status", 32'(rsp_status), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        lpc_reset = 1'b1;
        @(posedge lpc_clock); #2;

        // 1: IO write 0x0080 <- 0xA5, peripheral 1111 then 0000
        sync_src = '{4'hF, 4'h0};
        run_txn(1'b1, 1'b0, 32'h0000_0080, 8'hA5, 8'h00, md, ms, mdone, msync);
        chk("t1_model_nibbles", 32'(model_ad.size()), 32'd9);
        for (int i = 0; i < 9 && i < model_ad.size(); i++)
            chk("t1_model_nibble", 32'(model_ad[i]), 32'(lit1[i]));
        chk("t1_model_latency", 32'(mdone), 32'd15);
        chk("t1_dut_latency", 32'(rsp_idx), 32'd15);
        chk("t1_status", 32'(last_status), 32'd0);

        // 2: mem read 0xFFFFFFF0, three long waits then ready, data C,3
        sync_src = '{4'h6, 4'h6, 4'h6, 4'h0};
        run_txn(1'b0, 1'b1, 32'hFFFF_FFF0, 8'h00, 8'h3C, md, ms, mdone, msync);
        chk("t2_model_data", 32'(md), 32'h3C);
        chk("t2_model_latency", 32'(mdone), 32'd21);
        chk("t2_dut_data", 32'(last_data), 32'h3C);
        chk("t2_dut_status", 32'(last_status), 32'd0);

        // 3: IO read, peripheral never answers
        sync_src.delete();
        for (int i = 0; i < 20; i++) sync_src.push_back(4'hF);
        run_txn(1'b0, 1'b0, 32'h0000_0060, 8'h00, 8'h00, md, ms, mdone, msync);
        chk("t3_model_sync_clocks", 32'(msync), 32'd8);
        chk("t3_dut_status", 32'(last_status), 32'd2);
        chk("t3_dut_data", 32'(last_data), 32'd0);

        // 4: IO read with error sync, data 7,E
        sync_src = '{4'hA};
        run_txn(1'b0, 1'b0, 32'h0000_03F8, 8'h00, 8'hE7, md, ms, mdone, msync);
        chk("t4_model_status", 32'(ms), 32'd1);
        chk("t4_dut_data", 32'(last_data), 32'hE7);
        chk("t4_dut_status", 32'(last_status), 32'd1);

        // 5: mem write, endless long waits, then a normal IO read
        sync_src.delete();
        for (int i = 0; i < 300; i++) sync_src.push_back(4'h6);
        run_txn(1'b1, 1'b1, 32'h1234_5678, 8'h5A, 8'h00, md, ms, mdone, msync);
        chk("t5_model_sync_clocks", 32'(msync), 32'd256);
        chk("t5_dut_status", 32'(last_status), 32'd2);
        sync_src = '{4'h5, 4'h0};
        run_txn(1'b0, 1'b0, 32'h0000_002E, 8'h00, 8'h21, md, ms, mdone, msync);
        chk("t5b_dut_data", 32'(last_data), 32'h21);
        chk("t5b_dut_status", 32'(last_status), 32'd0);

        // 6: reset during ADDR nibble 2 of an IO write to 0x1234
        req_write = 1'b1; req_mem = 1'b0; req_addr = 32'h0000_1234; req_data = 8'h11;
        req_valid = 1'b1;
        for (int g = 0; g < 20 && !req_ready; g++) begin
            @(posedge lpc_clock); #2;
        end
        chk("t6_ready", 32'(req_ready), 32'd1);
        @(posedge lpc_clock); #2;
        req_valid = 1'b0;
        repeat (4) @(posedge lpc_clock);
        #2;
        chk("t6_addr2_nibble", 32'(lpc_ad_out), 32'h3);
        chk("t6_addr2_oe", 32'(lpc_ad_oe), 32'd1);
        lpc_reset = 1'b0;
        @(posedge lpc_clock); #2;
        chk("t6_frame", 32'(lpc_frame), 32'd1);
        chk("t6_oe", 32'(lpc_ad_oe), 32'd0);
        chk("t6_ad", 32'(lpc_ad_out), 32'hF);
        chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t6_ready_in_reset", 32'(req_ready), 32'd0);
        lpc_reset = 1'b1;
        begin
            int seen_rv = 0;
            int got_ready = 0;
            for (int g = 0; g < 20; g++) begin
                @(posedge lpc_clock); #2;
                if (rsp_valid) seen_rv++;
                if (req_ready) got_ready = 1;
            end
            chk("t6_no_rsp_valid", 32'(seen_rv), 32'd0);
            chk("t6_ready_after_release", 32'(got_ready), 32'd1);
            chk("t6_frame_idle", 32'(lpc_frame), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
